// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Produces 8 packed BCD digits for a 7-segment scanner; values above
// 99,999,999 saturate to all nines with ovf set.
module bin2bcd_seq #(
    parameter int unsigned BIN_W = 27  // legal range 1..27
) (
    input  logic             clk,
    input  logic             reset,     // asynchronous, active low
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [31:0]      digit,
    output logic             ovf
);

    localparam int unsigned      CntW    = $clog2(BIN_W + 1);
    localparam logic [CntW-1:0]  CntLast = CntW'(BIN_W - 1);
    localparam logic [31:0]      MaxDec  = 32'd99_999_999;
    localparam logic [31:0]      SatBcd  = 32'h9999_9999;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [BIN_W-1:0]  sr_q, sr_d;
    logic [31:0]       bcd_q, bcd_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              ovf_pend_q, ovf_pend_d;
    logic [31:0]       digit_q, digit_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    // Next-state logic: capture in idle, one double-dabble step per shift cycle,
    // publish result (saturated if needed) on the done edge.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        digit_d    = digit_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sr_d       = bin;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (32'(bin) > MaxDec);
                    state_d    = StShift;
                end
            end
            StShift: begin
                // Add 3 to every nibble >= 5 so the following shift carries correctly.
                for (int i = 0; i < 8; i++) begin
                    if (bcd_d[4*i +: 4] >= 4'd5) begin
                        bcd_d[4*i +: 4] = bcd_d[4*i +: 4] + 4'd3;
                    end
                end
                bcd_d = {bcd_d[30:0], sr_q[BIN_W-1]};
                sr_d  = sr_q << 1;
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                digit_d = ovf_pend_q ? SatBcd : bcd_q;
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            sr_q       <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            digit_q    <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            digit_q    <= digit_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    // Outputs: busy covers both shift and done states so start is ignored there.
    always_comb begin
        busy  = (state_q != StIdle);
        done  = done_q;
        digit = digit_q;
        ovf   = ovf_q;
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed scenarios plus random values,
// with a scoreboard queue of expected {ovf, digit} popped on every done pulse.
module tb_bin2bcd_seq;

    localparam int unsigned BIN_W = 27;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [BIN_W-1:0] bin   = '0;
    logic             busy;
    logic             done;
    logic [31:0]      digit;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    logic [32:0] sb_q[$];
    logic [32:0] last_exp = '0;

    bin2bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .digit (digit),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decimal conversion with saturation; bit 32 is the overflow flag.
    function automatic logic [32:0] model(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        if (v > 99_999_999) return {1'b1, 32'h9999_9999};
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return {1'b0, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                logic [32:0] e;
                e = sb_q.pop_front();
                check("digit", digit, e[31:0]);
                check("ovf", {31'd0, ovf}, {31'd0, e[32]});
                last_exp = e;
            end
        end
    end

    // Waits for done; counts edges, busy samples, and whether outputs held steady.
    task automatic wait_done(input int budget, output int n, output int b, output bit hold);
        n = 0;
        b = 0;
        hold = 1'b1;
        while (done !== 1'b1 && n < budget) begin
            if (busy === 1'b1) b++;
            if (digit !== last_exp[31:0] || ovf !== last_exp[32]) hold = 1'b0;
            tick();
            n++;
        end
    endtask

    // Drives one conversion, scrambles bin while busy, and checks timing.
    task automatic run_conv(input string tag, input int unsigned v, input bit full);
        int n;
        int b;
        bit hold;
        start = 1'b1;
        bin   = BIN_W'(v);
        sb_q.push_back(model(v));
        tick();
        start = 1'b0;
        bin   = BIN_W'($urandom);
        wait_done(60, n, b, hold);
        if (full) begin
            check({tag, "_latency"}, n, 32'd28);
            check({tag, "_busy_cycles"}, b, 32'd28);
            check({tag, "_hold"}, {31'd0, hold}, 32'd1);
        end else begin
            check({tag, "_latency"}, n, 32'd28);
        end
    endtask

    initial begin
        int n;
        int b;
        bit hold;

        // Reset state
        #3 reset = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_digit", digit, 32'h0000_0000);
        reset = 1'b1;

        // First edge after release accepts start; zero converts to zero
        run_conv("zero", 0, 1'b1);
        check("zero_busy_after", {31'd0, busy}, 32'd0);

        run_conv("d12345678", 12_345_678, 1'b1);
        run_conv("d99999999", 99_999_999, 1'b1);
        run_conv("d100000000", 100_000_000, 1'b1);
        run_conv("d134217727", 134_217_727, 1'b1);
        run_conv("d9", 9, 1'b1);

        // Start while busy is ignored; start in the done cycle is accepted
        start = 1'b1;
        bin   = BIN_W'(42);
        sb_q.push_back(model(42));
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        start = 1'b1;
        bin   = BIN_W'(7);
        tick();
        start = 1'b0;
        wait_done(60, n, b, hold);
        check("ignored_start_latency", n, 32'd18);
        check("done_cycle_busy", {31'd0, busy}, 32'd0);
        run_conv("b2b7", 7, 1'b0);
        for (int i = 0; i < 40; i++) tick();
        check("b2b_sb_empty", sb_q.size(), 32'd0);

        // Reset mid-conversion aborts with no done afterwards
        start = 1'b1;
        bin   = BIN_W'(555);
        sb_q.push_back(model(555));
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        check("pre_abort_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_digit", digit, 32'h0000_0000);
        check("abort_done", {31'd0, done}, 32'd0);
        sb_q.delete();
        last_exp = '0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check("post_abort_busy", {31'd0, busy}, 32'd0);
        check("post_abort_digit", digit, 32'h0000_0000);
        run_conv("d555", 555, 1'b1);

        // Random values across the full input range
        for (int i = 0; i < 1000; i++) begin
            int unsigned v;
            v = $urandom % (1 << BIN_W);
            if (i % 4 == 0) v = v % 100_000;
            run_conv("rand", v, 1'b0);
        end

        for (int i = 0; i < 40; i++) tick();
        check("final_sb_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter: BIN_W, default 27, binary input width; legal range 1..27, so 8 BCD digits always suffice.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; asserts immediately while low, releases synchronously to clk.
REQ-004 Port: start  input  1  conversion request, sampled on the rising edge.
REQ-005 Port: bin  input  BIN_W  unsigned binary value, sampled only on the edge that accepts start.
REQ-006 Port: busy  output  1  high while a conversion is in progress, so a new start is not accepted.
REQ-007 Port: done  output  1  single-cycle pulse marking that digit/ovf hold a new result.
REQ-008 Port: digit  output  32  8 packed BCD nibbles, digit[3:0] least significant; feeds the 7-segment scanner's digit input.
REQ-009 Port: ovf  output  1  high when the last converted value exceeded 99,999,999.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-011 In IDLE with start=1 at an edge, the block SHALL capture bin into a shift register, clear the 32-bit BCD accumulator, clear the iteration counter, compute the overflow flag (bin > 99,999,999), set busy=1 and go to SHIFT.
REQ-012 In IDLE with start=0, the block SHALL hold all outputs unchanged.
REQ-013 In SHIFT, each edge SHALL add 3 to every BCD nibble >= 5, then shift {BCD, binary} left one bit, with the binary MSB entering BCD bit 0.
REQ-014 SHIFT SHALL last exactly BIN_W edges; the counter SHALL be wide enough for BIN_W and SHALL not wrap early.
REQ-015 On leaving SHIFT, the block SHALL enter DONE; in DONE the next edge SHALL load digit and ovf, pulse done=1 for one cycle, clear busy and return to IDLE.
REQ-016 Latency: done SHALL be high in the cycle after edge BIN_W+1 after the edge that accepted start (edge 28 at the default), and busy SHALL be high for exactly BIN_W+1 cycles.
REQ-017 If ovf is computed as 1, digit SHALL be loaded with 32'h9999_9999 instead of the accumulator (saturation).
REQ-018 start while busy=1, including in DONE, SHALL be ignored without being queued; bin changes during a conversion SHALL not affect the result.
REQ-019 start asserted in the same cycle that done pulses SHALL be accepted (state is IDLE), allowing back-to-back conversions every BIN_W+2 cycles.
REQ-020 digit and ovf SHALL change only on the done edge; they SHALL hold the previous result throughout a conversion, so the display never shows partial values.
REQ-021 Every digit nibble SHALL be in the range 0..9 after any completed conversion.

Reset
REQ-022 While reset=0, the block SHALL be in state IDLE and SHALL hold busy=0, done=0, ovf=0, digit=32'h0000_0000, and counter, accumulator and shift register all 0.
REQ-023 Reset asserted mid-conversion SHALL abort the conversion immediately; no done pulse SHALL follow after release.
REQ-024 On the first edge after reset release, the block SHALL accept start normally.

Verification
REQ-025 The bench SHALL cover: bin=0, start pulse -> done at edge 28, digit=32'h0000_0000, ovf=0.
REQ-026 The bench SHALL cover: bin=12,345,678 -> digit=32'h1234_5678, ovf=0, busy high for exactly 28 cycles.
REQ-027 The bench SHALL cover: bin=99,999,999 -> digit=32'h9999_9999, ovf=0; then bin=100,000,000 -> digit=32'h9999_9999, ovf=1.
REQ-028 The bench SHALL cover: start at bin=42, then start at bin=7 on edge 10 of that conversion -> single done, digit=32'h0000_0042; then start in the done cycle with bin=7 -> next done, digit=32'h0000_0007.
REQ-029 The bench SHALL cover: start at bin=555, reset low at edge 12, released 3 cycles later -> busy=0, digit=0, no done pulse; then a new conversion of 555 -> digit=32'h0000_0555.
REQ-030 The bench SHALL cover: random bin values in 0..2^27-1 (at least 1000) -> digit matches a reference decimal conversion, or saturation with ovf when bin > 99,999,999.
